// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle core control FSM: states, opcodes,
// datapath mux encodings and the per-state Moore output decode.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_ILLEGAL
  } state_e;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'b00,
    RES_DATA   = 2'b01,
    RES_ALU    = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } src_a_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_e;

  // fetch/branch/jal flags select which condition gates pc_write and ir_write
  typedef struct packed {
    logic        mem_req;
    logic        mem_write;
    logic        adr_src;
    logic        reg_write;
    logic        illegal;
    result_src_e result_src;
    src_a_e      src_a;
    src_b_e      src_b;
    alu_op_e     alu_op;
    logic        fetch;
    logic        branch;
    logic        jal;
  } ctrl_t;

  function automatic ctrl_t decode_state(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.src_a      = SRCA_PC;
        c.src_b      = SRCB_FOUR;
        c.alu_op     = ALU_ADD;
        c.result_src = RES_ALU;
        c.fetch      = 1'b1;
      end
      S_DECODE: begin
        c.src_a  = SRCA_OLDPC;
        c.src_b  = SRCB_IMM;
        c.alu_op = ALU_ADD;
      end
      S_MEMADR: begin
        c.src_a  = SRCA_RS1;
        c.src_b  = SRCB_IMM;
        c.alu_op = ALU_ADD;
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.adr_src   = 1'b1;
      end
      S_EXECR: begin
        c.src_a  = SRCA_RS1;
        c.src_b  = SRCB_RS2;
        c.alu_op = ALU_FUNCT;
      end
      S_EXECI: begin
        c.src_a  = SRCA_RS1;
        c.src_b  = SRCB_IMM;
        c.alu_op = ALU_FUNCT;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        c.src_a      = SRCA_RS1;
        c.src_b      = SRCB_RS2;
        c.alu_op     = ALU_SUB;
        c.result_src = RES_ALUOUT;
        c.branch     = 1'b1;
      end
      S_JAL: begin
        c.src_a      = SRCA_OLDPC;
        c.src_b      = SRCB_FOUR;
        c.alu_op     = ALU_ADD;
        c.result_src = RES_ALUOUT;
        c.jal        = 1'b1;
      end
      S_ILLEGAL: begin
        c.illegal = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_next_state.sv
// Combinational next-state function of the multicycle control FSM.
module mc_next_state
  import multicycle_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [6:0] op_i,
  input  logic       mem_ready_i,
  output state_e     next_state
);

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    if (mem_ready_i) next_state = S_DECODE;
      S_DECODE: begin
        case (op_i)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_BRANCH:    next_state = S_BRANCH;
          OP_JAL:       next_state = S_JAL;
          default:      next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   next_state = (op_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready_i) next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: if (mem_ready_i) next_state = S_FETCH;
      S_EXECR:    next_state = S_ALUWB;
      S_EXECI:    next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
      S_ILLEGAL:  next_state = S_FETCH;
      default:    next_state = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I-subset core.
// Optional feature: define MC_BNE_EN to make funct3 == 001 branches behave as bne.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       adr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       illegal_o
);

  state_e state_q;
  state_e next_state;
  ctrl_t  ctrl_q;
  logic   branch_take;

  mc_next_state u_next_state (
    .state       (state_q),
    .op_i        (op_i),
    .mem_ready_i (mem_ready_i),
    .next_state  (next_state)
  );

  // Moore outputs are precomputed from the state being entered so they come straight from flops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode_state(S_FETCH);
    end else begin
      state_q <= next_state;
      ctrl_q  <= decode_state(next_state);
    end
  end

`ifdef MC_BNE_EN
  assign branch_take = zero_i ^ (funct3_i == 3'b001);
`else
  logic unused_funct3;
  assign unused_funct3 = ^funct3_i;
  assign branch_take   = zero_i;
`endif

  // Reset silences every output in the same cycle, so an aborted access never writes
  always_comb begin
    mem_req_o    = ctrl_q.mem_req;
    mem_write_o  = ctrl_q.mem_write;
    adr_src_o    = ctrl_q.adr_src;
    reg_write_o  = ctrl_q.reg_write;
    illegal_o    = ctrl_q.illegal;
    result_src_o = ctrl_q.result_src;
    alu_src_a_o  = ctrl_q.src_a;
    alu_src_b_o  = ctrl_q.src_b;
    alu_op_o     = ctrl_q.alu_op;
    ir_write_o   = ctrl_q.fetch & mem_ready_i;
    pc_write_o   = (ctrl_q.fetch & mem_ready_i) | (ctrl_q.branch & branch_take) | ctrl_q.jal;
    if (rst_i) begin
      mem_req_o    = 1'b0;
      mem_write_o  = 1'b0;
      adr_src_o    = 1'b0;
      reg_write_o  = 1'b0;
      illegal_o    = 1'b0;
      result_src_o = 2'b00;
      alu_src_a_o  = 2'b00;
      alu_src_b_o  = 2'b00;
      alu_op_o     = 2'b00;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; one output vector checked per cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [14:0] obs;

  int assertCount = 0;
  int failCount = 0;

  // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, result_src, src_a, src_b, alu_op, illegal}
  localparam logic [14:0] EXP_RST    = 15'b0_0_0_0_0_0_00_00_00_00_0;
  localparam logic [14:0] EXP_F_RDY  = 15'b1_0_0_1_1_0_10_00_10_00_0;
  localparam logic [14:0] EXP_F_WAIT = 15'b1_0_0_0_0_0_10_00_10_00_0;
  localparam logic [14:0] EXP_DEC    = 15'b0_0_0_0_0_0_00_01_01_00_0;
  localparam logic [14:0] EXP_MADR   = 15'b0_0_0_0_0_0_00_10_01_00_0;
  localparam logic [14:0] EXP_MRD    = 15'b1_0_1_0_0_0_00_00_00_00_0;
  localparam logic [14:0] EXP_MWB    = 15'b0_0_0_0_0_1_01_00_00_00_0;
  localparam logic [14:0] EXP_MWR    = 15'b1_1_1_0_0_0_00_00_00_00_0;
  localparam logic [14:0] EXP_EXR    = 15'b0_0_0_0_0_0_00_10_00_10_0;
  localparam logic [14:0] EXP_EXI    = 15'b0_0_0_0_0_0_00_10_01_10_0;
  localparam logic [14:0] EXP_AWB    = 15'b0_0_0_0_0_1_00_00_00_00_0;
  localparam logic [14:0] EXP_BR_TK  = 15'b0_0_0_0_1_0_00_10_00_01_0;
  localparam logic [14:0] EXP_BR_NT  = 15'b0_0_0_0_0_0_00_10_00_01_0;
  localparam logic [14:0] EXP_JAL    = 15'b0_0_0_0_1_0_00_01_10_00_0;
  localparam logic [14:0] EXP_ILL    = 15'b0_0_0_0_0_0_00_00_00_00_1;

  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_BAD = 7'b0000000;

  multicycle_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .op_i         (op),
    .funct3_i     (funct3),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .mem_req_o    (mem_req),
    .mem_write_o  (mem_write),
    .adr_src_o    (adr_src),
    .ir_write_o   (ir_write),
    .pc_write_o   (pc_write),
    .reg_write_o  (reg_write),
    .result_src_o (result_src),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op),
    .illegal_o    (illegal)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_op, illegal};

  // Inputs change on the falling edge and outputs are sampled 1 ns later
  task automatic applyStimulus(input logic r, input logic rdy, input logic z,
                               input logic [6:0] o, input logic [2:0] f3);
    @(negedge clk);
    rst       = r;
    mem_ready = rdy;
    zero      = z;
    op        = o;
    funct3    = f3;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [14:0] got, input logic [14:0] want);
    assertCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got %b expected %b", tag, got, want);
    end
  endtask

  task automatic runCycle(input string tag, input logic r, input logic rdy, input logic z,
                          input logic [6:0] o, input logic [2:0] f3, input logic [14:0] want);
    applyStimulus(r, rdy, z, o, f3);
    checkOutput(tag, obs, want);
  endtask

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b1;
    zero      = 1'b0;
    op        = OPC_R;
    funct3    = 3'b000;

    // reset held three cycles with mem_ready high
    for (int i = 0; i < 3; i++) runCycle("reset", 1, 1, 0, OPC_R, 3'b000, EXP_RST);

    // R-type, zero wait states
    runCycle("r_fetch",  0, 1, 0, OPC_R, 3'b000, EXP_F_RDY);
    runCycle("r_decode", 0, 1, 0, OPC_R, 3'b000, EXP_DEC);
    runCycle("r_execr",  0, 1, 0, OPC_R, 3'b000, EXP_EXR);
    runCycle("r_aluwb",  0, 1, 0, OPC_R, 3'b000, EXP_AWB);

    // lw with two wait cycles in MEMREAD
    runCycle("lw_fetch",  0, 1, 0, OPC_LW, 3'b010, EXP_F_RDY);
    runCycle("lw_decode", 0, 1, 0, OPC_LW, 3'b010, EXP_DEC);
    runCycle("lw_memadr", 0, 1, 0, OPC_LW, 3'b010, EXP_MADR);
    runCycle("lw_rd_w1",  0, 0, 0, OPC_LW, 3'b010, EXP_MRD);
    runCycle("lw_rd_w2",  0, 0, 0, OPC_LW, 3'b010, EXP_MRD);
    runCycle("lw_rd_ok",  0, 1, 0, OPC_LW, 3'b010, EXP_MRD);
    runCycle("lw_memwb",  0, 1, 0, OPC_LW, 3'b010, EXP_MWB);

    // beq taken then not taken
    runCycle("beq1_fetch",  0, 1, 1, OPC_BR, 3'b000, EXP_F_RDY);
    runCycle("beq1_decode", 0, 1, 1, OPC_BR, 3'b000, EXP_DEC);
    runCycle("beq1_branch", 0, 1, 1, OPC_BR, 3'b000, EXP_BR_TK);
    runCycle("beq0_fetch",  0, 1, 0, OPC_BR, 3'b000, EXP_F_RDY);
    runCycle("beq0_decode", 0, 1, 0, OPC_BR, 3'b000, EXP_DEC);
    runCycle("beq0_branch", 0, 1, 0, OPC_BR, 3'b000, EXP_BR_NT);

`ifdef MC_BNE_EN
    runCycle("bne1_fetch",  0, 1, 1, OPC_BR, 3'b001, EXP_F_RDY);
    runCycle("bne1_decode", 0, 1, 1, OPC_BR, 3'b001, EXP_DEC);
    runCycle("bne1_branch", 0, 1, 1, OPC_BR, 3'b001, EXP_BR_NT);
    runCycle("bne0_fetch",  0, 1, 0, OPC_BR, 3'b001, EXP_F_RDY);
    runCycle("bne0_decode", 0, 1, 0, OPC_BR, 3'b001, EXP_DEC);
    runCycle("bne0_branch", 0, 1, 0, OPC_BR, 3'b001, EXP_BR_TK);
`else
    runCycle("f3_fetch",  0, 1, 0, OPC_BR, 3'b001, EXP_F_RDY);
    runCycle("f3_decode", 0, 1, 0, OPC_BR, 3'b001, EXP_DEC);
    runCycle("f3_branch", 0, 1, 0, OPC_BR, 3'b001, EXP_BR_NT);
`endif

    // unsupported opcode, then a FETCH wait cycle on cycle 4
    runCycle("ill_fetch",   0, 1, 0, OPC_BAD, 3'b000, EXP_F_RDY);
    runCycle("ill_decode",  0, 1, 0, OPC_BAD, 3'b000, EXP_DEC);
    runCycle("ill_pulse",   0, 1, 0, OPC_BAD, 3'b000, EXP_ILL);
    runCycle("ill_back",    0, 0, 0, OPC_BAD, 3'b000, EXP_F_WAIT);

    // sw aborted by reset during a MEMWRITE wait
    runCycle("sw_fetch",   0, 1, 0, OPC_SW, 3'b010, EXP_F_RDY);
    runCycle("sw_decode",  0, 1, 0, OPC_SW, 3'b010, EXP_DEC);
    runCycle("sw_memadr",  0, 1, 0, OPC_SW, 3'b010, EXP_MADR);
    runCycle("sw_wait",    0, 0, 0, OPC_SW, 3'b010, EXP_MWR);
    runCycle("sw_wait2",   0, 0, 0, OPC_SW, 3'b010, EXP_MWR);
    runCycle("sw_reset",   1, 0, 0, OPC_SW, 3'b010, EXP_RST);
    runCycle("sw_resume",  0, 0, 0, OPC_SW, 3'b010, EXP_F_WAIT);

    // I-type and jal
    runCycle("i_fetch",    0, 1, 0, OPC_I, 3'b000, EXP_F_RDY);
    runCycle("i_decode",   0, 1, 0, OPC_I, 3'b000, EXP_DEC);
    runCycle("i_execi",    0, 1, 0, OPC_I, 3'b000, EXP_EXI);
    runCycle("i_aluwb",    0, 1, 0, OPC_I, 3'b000, EXP_AWB);
    runCycle("jal_fetch",  0, 1, 0, OPC_JAL, 3'b000, EXP_F_RDY);
    runCycle("jal_decode", 0, 1, 0, OPC_JAL, 3'b000, EXP_DEC);
    runCycle("jal_jal",    0, 1, 0, OPC_JAL, 3'b000, EXP_JAL);
    runCycle("jal_aluwb",  0, 1, 0, OPC_JAL, 3'b000, EXP_AWB);
    runCycle("end_fetch",  0, 1, 0, OPC_R, 3'b000, EXP_F_RDY);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle RV32I-subset core. It sequences the shared ALU, register file, instruction register and unified memory port across FETCH/DECODE/EXECUTE/WRITEBACK states. It drives `alu_op_o` into the existing ALU decoder, which turns it into the 3-bit ALU control. It supports memory wait states through a request/ready handshake.

## Interface
- No parameters.
- `clk_i`  in  1  core clock
- `rst_i`  in  1  synchronous, active-high reset
- `op_i`  in  7  opcode field of the instruction register
- `funct3_i`  in  3  funct3 of the instruction register; used only when `MC_BNE_EN` is defined
- `zero_i`  in  1  ALU zero flag
- `mem_ready_i`  in  1  memory completes the current access this cycle
- `mem_req_o`  out  1  memory access request
- `mem_write_o`  out  1  request is a store
- `adr_src_o`  out  1  address select: 0 = PC, 1 = ALU result register
- `ir_write_o`  out  1  load the instruction register
- `pc_write_o`  out  1  load the PC from the result bus
- `reg_write_o`  out  1  register file write enable
- `result_src_o`  out  2  result mux: 00 = ALUOut, 01 = data register, 10 = ALU result
- `alu_src_a_o`  out  2  A mux: 00 = PC, 01 = OldPC, 10 = rs1
- `alu_src_b_o`  out  2  B mux: 00 = rs2, 01 = immediate, 10 = constant 4
- `alu_op_o`  out  2  to ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded
- `illegal_o`  out  1  one-cycle pulse on an unsupported opcode

## Operation
- Moore FSM; all outputs decode from state alone, except `pc_write_o` and `ir_write_o`, which are gated by `mem_ready_i` or `zero_i` as noted.
- Any output not listed for a state is 0.
- States and outputs:
  - FETCH: `mem_req_o`=1, `adr_src_o`=0, `alu_src_a_o`=00, `alu_src_b_o`=10, `alu_op_o`=00, `result_src_o`=10. `ir_write_o` = `pc_write_o` = `mem_ready_i`. Stays in FETCH until `mem_ready_i`, then goes to DECODE.
  - DECODE: `alu_src_a_o`=01, `alu_src_b_o`=01, `alu_op_o`=00 (branch target). Next state by `op_i`:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - any other opcode -> ILLEGAL
  - MEMADR: `alu_src_a_o`=10, `alu_src_b_o`=01, `alu_op_o`=00. Goes to MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: `mem_req_o`=1, `adr_src_o`=1. Holds until `mem_ready_i`, then goes to MEMWB.
  - MEMWB: `result_src_o`=01, `reg_write_o`=1. Goes to FETCH.
  - MEMWRITE: `mem_req_o`=1, `mem_write_o`=1, `adr_src_o`=1. Holds until `mem_ready_i`, then goes to FETCH.
  - EXECR: `alu_src_a_o`=10, `alu_src_b_o`=00, `alu_op_o`=10. Goes to ALUWB.
  - EXECI: `alu_src_a_o`=10, `alu_src_b_o`=01, `alu_op_o`=10. Goes to ALUWB.
  - ALUWB: `result_src_o`=00, `reg_write_o`=1. Goes to FETCH.
  - BRANCH: `alu_src_a_o`=10, `alu_src_b_o`=00, `alu_op_o`=01, `result_src_o`=00, `pc_write_o`=`zero_i`. Goes to FETCH.
  - JAL: `alu_src_a_o`=01, `alu_src_b_o`=10, `alu_op_o`=00, `result_src_o`=00, `pc_write_o`=1. Goes to ALUWB (writes rd = PC+4).
  - ILLEGAL: `illegal_o`=1, no writes. Goes to FETCH.
- `mem_req_o` and `mem_write_o` stay stable while waiting. The memory must not see a request drop before `mem_ready_i`.
- `mem_ready_i` is ignored in every state that does not assert `mem_req_o`.

## Timing
- Reset: state = FETCH on the first edge with `rst_i`=1.
  - While `rst_i` is high, all outputs are 0 except `mem_req_o`=0. Request is suppressed during reset.
  - From the first cycle after `rst_i` falls, outputs follow FETCH.
- Reset mid-instruction aborts it. No register or memory write is issued in the reset cycle.
- Cycles per instruction at zero wait states:
  - lw: 5
  - sw: 4
  - R-type, I-type, jal: 4
  - branch: 3
  - illegal: 3
- Each wait cycle adds one cycle to FETCH, MEMREAD or MEMWRITE.
- `mem_ready_i` and `zero_i` act combinationally on the `pc_write_o`/`ir_write_o` gating in the same cycle.

## Configuration
- `MC_BNE_EN` defined: in BRANCH, `pc_write_o` = `zero_i` XOR (`funct3_i`==001). This gives bne. Any funct3 other than 000 or 001 behaves as beq.
- `MC_BNE_EN` undefined: `funct3_i` is unused, and every branch is beq.

## Structure
- Shared core package holds:
  - the state enum
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BRANCH, OP_JAL)
  - ALU-op, result-source, src-A and src-B encodings as typedef'd enums
- One sub-module, `mc_next_state`: the combinational next-state function of (state, `op_i`, `mem_ready_i`). The top holds the state register and the output decode.

## Test plan
- Reset held 3 cycles with `mem_ready_i`=1 -> all outputs 0. First cycle after release: `mem_req_o`=1, `ir_write_o`=1, `pc_write_o`=1.
- R-type (`op_i`=0110011), zero wait states -> states FETCH, DECODE, EXECR, ALUWB. `alu_op_o`=10 in EXECR. `reg_write_o`=1 for exactly one cycle.
- lw with `mem_ready_i` low for 2 cycles in MEMREAD -> `mem_req_o` and `adr_src_o` steady for 3 cycles. MEMWB follows with `result_src_o`=01. Total 7 cycles.
- beq with `zero_i`=1, then with `zero_i`=0 -> `pc_write_o` pulses once in BRANCH for the first and stays 0 for the second. With `MC_BNE_EN` and `funct3_i`=001, the result is inverted.
- `op_i`=0000000 -> single-cycle `illegal_o` pulse, no write enables, back in FETCH on cycle 4.
- `rst_i` asserted during MEMWRITE wait -> `mem_write_o` low in the reset cycle. FETCH resumes after reset.
